load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU/register-file datapath.
- Takes the ALU-computed effective address, the RS2 store data and func3 from decode, and runs a multi-cycle request/grant/response transaction on the data-memory bus.
- Returns sign- or zero-extended load data for register write-back.
- Stalls the fetch unit while a transaction is in flight.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the memory system.
//   mem_req    : bus request, held until mem_gnt
//   mem_we     : 1 = write
//   mem_addr   : word-aligned address
//   mem_wdata  : lane-replicated store data
//   mem_be     : byte enables
//   mem_gnt    : request accepted
//   mem_rvalid : read response / store acknowledge
//   mem_rdata  : read word
// master = load/store unit side, slave = memory side.
`timescale 1ns/1ps
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: turns an RV32I load/store (effective address, RS2 data, func3) into a
// request/grant/response transaction on the data-memory bus and returns extended load data.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   ls_valid_i, ls_we_i    : instruction is a load/store; 1 = store
//   func3_i, addr_i, wdata_i : width/sign code, effective address, store data
//   stall_o                : freeze fetch while a transaction is pending
//   done_o                 : one-cycle completion pulse; rdata_o and err_o valid with it
//   mem                    : data-memory bus (master side)
// TIMEOUT_CYCLES bounds the cycles spent in REQ+WAIT (1..255).
`timescale 1ns/1ps
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     ls_valid_i,
   input  logic                     ls_we_i,
   input  logic [2:0]               func3_i,
   input  logic [31:0]              addr_i,
   input  logic [31:0]              wdata_i,
   output logic                     stall_o,
   output logic                     done_o,
   output logic [31:0]              rdata_o,
   output logic                     err_o,
   load_store_unit_if.master        mem
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   // Last counter value before the abort; the counter starts at 0 in the first REQ cycle.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  func3_q, func3_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        misaligned;
   logic        func3_ok;
   logic        legal;
   logic        timed_out;
   logic [1:0]  lane;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   // Access legality, evaluated on the incoming instruction in IDLE.
   always_comb begin
      misaligned = 1'b1;
      unique case (func3_i[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_i[0];
         2'b10:   misaligned = |addr_i[1:0];
         default: misaligned = 1'b1;
      endcase
      if (ls_we_i) begin
         func3_ok = !func3_i[2] && (func3_i[1:0] != 2'b11);
      end else begin
         func3_ok = (func3_i != 3'd3) && (func3_i != 3'd6) && (func3_i != 3'd7);
      end
      legal = func3_ok && !misaligned;
   end

   // Bus lane steering from the latched access.
   assign lane = addr_q[1:0];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata_q;
      unique case (func3_q[1:0])
         2'b00: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
   end

   // Load extraction and extension.
   always_comb begin
      byte_sel = mem.mem_rdata[7:0];
      unique case (lane)
         2'd0: byte_sel = mem.mem_rdata[7:0];
         2'd1: byte_sel = mem.mem_rdata[15:8];
         2'd2: byte_sel = mem.mem_rdata[23:16];
         2'd3: byte_sel = mem.mem_rdata[31:24];
      endcase
      half_sel = lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      unique case (func3_q)
         3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd4:    load_data = {24'd0, byte_sel};
         3'd5:    load_data = {16'd0, half_sel};
         default: load_data = mem.mem_rdata;
      endcase
   end

   assign timed_out = (cnt_q >= TimeoutLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      func3_d = func3_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (ls_valid_i) begin
               if (legal) begin
                  state_d = StReq;
                  cnt_d   = 8'd0;
                  addr_d  = addr_i;
                  wdata_d = wdata_i;
                  func3_d = func3_i;
                  we_d    = ls_we_i;
               end else begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end
            end
         end
         StReq: begin
            cnt_d = cnt_q + 8'd1;
            // Timeout wins over a grant so REQ+WAIT never exceeds TIMEOUT_CYCLES.
            if (timed_out) begin
               state_d = StResp;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (mem.mem_gnt) begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            if (timed_out) begin
               state_d = StResp;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (mem.mem_rvalid) begin
               state_d = StResp;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : load_data;
            end
         end
         StResp: begin
            state_d = StIdle;
            err_d   = 1'b0;
            rdata_d = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         func3_q <= 3'd0;
         we_q    <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         func3_q <= func3_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus outputs are decoded from state so reset drops the request immediately.
   assign mem.mem_req   = (state_q == StReq);
   assign mem.mem_we    = mem.mem_req & we_q;
   assign mem.mem_addr  = mem.mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem.mem_wdata = mem.mem_req ? wdata_rep : 32'd0;
   assign mem.mem_be    = mem.mem_req ? be : 4'd0;

   assign stall_o = ((state_q == StIdle) & ls_valid_i) | (state_q == StReq) |
                    (state_q == StWait);
   assign done_o  = (state_q == StResp);
   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ls_valid, ls_valid2, ls_we;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;
   logic        stall, done, err, stall2, done2, err2;
   logic [31:0] rdata, rdata2;

   always #5 clk = ~clk;

   load_store_unit_if bus ();
   load_store_unit_if bus2 ();

   load_store_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .ls_valid_i(ls_valid), .ls_we_i(ls_we),
      .func3_i(func3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
      .rdata_o(rdata), .err_o(err), .mem(bus)
   );

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk_i(clk), .rst_ni(rst_n), .ls_valid_i(ls_valid2), .ls_we_i(ls_we),
      .func3_i(func3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall2), .done_o(done2),
      .rdata_o(rdata2), .err_o(err2), .mem(bus2)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rword;
      int          gd, rd;
      bit          early;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      bit          done, done_after, unstable;
      logic [31:0] rdata, addr, wdata;
      logic        err, we;
      logic [3:0]  be;
      int          req_n, stall_n, done_cyc;
   } res_t;

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] w, input int gd,
                               input int rd, input bit early, input logic [31:0] er,
                               input logic ee, input logic [3:0] eb, input logic [31:0] ew);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = d; v.rword = w; v.gd = gd; v.rd = rd;
      v.early = early; v.exp_rdata = er; v.exp_err = ee; v.exp_be = eb; v.exp_wdata = ew;
      return v;
   endfunction

   // Reference model: RV32I access rules in plain arithmetic.
   function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int size;
      bit ok;
      if (we) ok = (f3 <= 3'd2);
      else    ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      size = 1 << (f3 % 4);
      return ok && ((a % size) == 0);
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int lane = int'(a % 4);
      case (f3 % 4)
         0:       return 4'(1 << lane);
         1:       return (lane >= 2) ? 4'd12 : 4'd3;
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3 % 4)
         0:       return (d % 256) * 32'h0101_0101;
         1:       return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      int lane = int'(a % 4);
      b = (w >> (8 * lane)) % 256;
      h = (w >> (16 * (lane / 2))) % 65536;
      case (f3)
         0:       return (b >= 128) ? b - 256 : b;
         1:       return (h >= 32768) ? h - 65536 : h;
         4:       return b;
         5:       return h;
         default: return w;
      endcase
   endfunction

   // Drives one instruction and plays the memory side; returns what the bus and outputs did.
   task automatic run_txn(input vec_t v, output res_t r);
      int req_n = 0, wait_n = 0;
      bit granted = 0, responded = 0;
      r = '{default: 0};
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            ls_valid = 1'b1; ls_we = v.we; func3 = v.f3; addr = v.addr; wdata = v.wdata;
         end
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
         if (bus.mem_req) begin
            if (req_n == v.gd) bus.mem_gnt = 1'b1;
            if (v.early) bus.mem_rvalid = 1'b1;  // stray response while still requesting
         end else if (granted && !responded) begin
            if (wait_n == v.rd) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = v.rword;
               responded = 1;
            end
            wait_n++;
         end
         @(negedge clk);
         if (stall) r.stall_n++;
         if (bus.mem_req) begin
            if (req_n == 0) begin
               r.addr = bus.mem_addr; r.be = bus.mem_be; r.wdata = bus.mem_wdata;
               r.we = bus.mem_we;
            end else if (bus.mem_addr !== r.addr || bus.mem_be !== r.be ||
                         bus.mem_wdata !== r.wdata || bus.mem_we !== r.we) begin
               r.unstable = 1;
            end
            req_n++;
            if (bus.mem_gnt) granted = 1;
         end
         if (done) begin
            r.done = 1; r.rdata = rdata; r.err = err; r.done_cyc = cyc;
            break;
         end
      end
      r.req_n = req_n;
      @(posedge clk); #1;
      ls_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      @(negedge clk);
      r.done_after = done;
   endtask

   task automatic check_txn(input string tag, input vec_t v, input res_t r);
      int lat = v.exp_err ? 1 : v.gd + v.rd + 3;
      check({tag, " done"}, 32'(r.done), 32'd1);
      check({tag, " err"}, 32'(r.err), 32'(v.exp_err));
      check({tag, " rdata"}, r.rdata, v.exp_rdata);
      check({tag, " done_latency"}, r.done_cyc, lat);
      check({tag, " stall_cycles"}, r.stall_n, lat);
      check({tag, " done_single"}, 32'(r.done_after), 32'd0);
      check({tag, " req_cycles"}, r.req_n, v.exp_err ? 0 : v.gd + 1);
      if (!v.exp_err) begin
         check({tag, " mem_addr"}, r.addr, v.addr - (v.addr % 4));
         check({tag, " mem_be"}, 32'(r.be), 32'(v.exp_be));
         check({tag, " mem_we"}, 32'(r.we), 32'(v.we));
         check({tag, " bus_stable"}, 32'(r.unstable), 32'd0);
         if (v.we) check({tag, " mem_wdata"}, r.wdata, v.exp_wdata);
      end
   endtask

   vec_t tbl[13];
   vec_t v;
   res_t r;

   initial begin
      tbl[0]  = mk(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 4'hF, 0);
      tbl[1]  = mk(0, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 0, 32'hFFFFFF80, 0, 4'h8, 0);
      tbl[2]  = mk(0, 3'd4, 32'h103, 0, 32'h80112233, 1, 0, 0, 32'h00000080, 0, 4'h8, 0);
      tbl[3]  = mk(0, 3'd5, 32'h102, 0, 32'h80112233, 0, 1, 0, 32'h00008011, 0, 4'hC, 0);
      tbl[4]  = mk(1, 3'd1, 32'h202, 32'h1234ABCD, 32'h55555555, 3, 1, 0, 0, 0, 4'hC,
                   32'hABCDABCD);
      tbl[5]  = mk(0, 3'd2, 32'h101, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[6]  = mk(1, 3'd4, 32'h200, 32'h1, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[7]  = mk(0, 3'd1, 32'h100, 0, 32'h1234F00D, 0, 0, 1, 32'hFFFFF00D, 0, 4'h3, 0);
      tbl[8]  = mk(1, 3'd0, 32'h301, 32'h000000A5, 0, 2, 0, 0, 0, 0, 4'h2, 32'hA5A5A5A5);
      tbl[9]  = mk(1, 3'd2, 32'h304, 32'hCAFEF00D, 0, 1, 2, 1, 0, 0, 4'hF, 32'hCAFEF00D);
      tbl[10] = mk(0, 3'd1, 32'h103, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[11] = mk(0, 3'd6, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[12] = mk(0, 3'd0, 32'h101, 0, 32'h00007F00, 0, 0, 0, 32'h0000007F, 0, 4'h2, 0);

      rst_n = 1'b0; ls_valid = 1'b0; ls_valid2 = 1'b0; ls_we = 1'b0; func3 = 3'd0;
      addr = 32'd0; wdata = 32'd0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      bus2.mem_gnt = 1'b0; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = 32'd0;
      #12;
      check("reset mem_req", 32'(bus.mem_req), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset mem_be", 32'(bus.mem_be), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_txn(tbl[i], r);
         check_txn($sformatf("vec%0d", i), tbl[i], r);
      end

      for (int i = 0; i < 60; i++) begin
         v.we = 1'($urandom % 2); v.f3 = 3'($urandom % 8);
         v.addr = $urandom;
         if ($urandom % 2) v.addr = v.addr - (v.addr % 4);
         v.wdata = $urandom; v.rword = $urandom;
         v.gd = int'($urandom % 4); v.rd = int'($urandom % 3); v.early = 1'($urandom % 2);
         v.exp_err = !ref_legal(v.we, v.f3, v.addr);
         v.exp_rdata = (v.exp_err || v.we) ? 32'd0 : ref_load(v.f3, v.addr, v.rword);
         v.exp_be = ref_be(v.f3, v.addr);
         v.exp_wdata = ref_wdata(v.f3, v.wdata);
         run_txn(v, r);
         check_txn($sformatf("rnd%0d", i), v, r);
      end

      // Timeout: grant never arrives on the short-timeout instance.
      begin
         int req_n = 0;
         bit seen = 0;
         logic req_at_done = 1'b1;
         logic [31:0] got_rdata = 32'hX;
         logic got_err = 1'b0;
         int done_cyc = -1;
         for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
               ls_valid2 = 1'b1; ls_we = 1'b0; func3 = 3'd2; addr = 32'h40;
            end
            @(negedge clk);
            if (bus2.mem_req) req_n++;
            if (done2) begin
               seen = 1; got_rdata = rdata2; got_err = err2; done_cyc = cyc;
               req_at_done = bus2.mem_req;
               break;
            end
         end
         check("timeout done", 32'(seen), 32'd1);
         check("timeout req_cycles", req_n, 4);
         check("timeout err", 32'(got_err), 32'd1);
         check("timeout rdata", got_rdata, 32'd0);
         check("timeout latency", done_cyc, 5);
         check("timeout req_dropped", 32'(req_at_done), 32'd0);
         @(posedge clk); #1;
         ls_valid2 = 1'b0;
         for (int k = 0; k < 3; k++) begin
            bus2.mem_rvalid = 1'b1; bus2.mem_rdata = $urandom;
            @(negedge clk);
            check($sformatf("stray_rvalid done%0d", k), 32'(done2), 32'd0);
            check($sformatf("stray_rvalid stall%0d", k), 32'(stall2), 32'd0);
            @(posedge clk); #1;
         end
         bus2.mem_rvalid = 1'b0;
      end

      // Asynchronous reset while waiting for a response.
      @(posedge clk); #1;
      ls_valid = 1'b1; ls_we = 1'b0; func3 = 3'd2; addr = 32'h80;
      @(posedge clk); #1;
      check("rst_seq req", 32'(bus.mem_req), 32'd1);
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; ls_valid = 1'b0;
      check("rst_seq wait_stall", 32'(stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_async stall", 32'(stall), 32'd0);
      check("rst_async done", 32'(done), 32'd0);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      check("rst_held done", 32'(done), 32'd0);
      bus.mem_rvalid = 1'b0;
      rst_n = 1'b1;
      v = mk(0, 3'd2, 32'h84, 0, 32'h13572468, 0, 0, 0, 32'h13572468, 0, 4'hF, 0);
      run_txn(v, r);
      check_txn("post_reset", v, r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
